// File: rtl/airlock_pkg.sv
// airlock_pkg
//   Shared types and constants for the airlock pressure sequencer.
//   airlock_state_t : sequencer state (IDLE, EVAC, PRESS, FAULT)
//   FAULT_*         : values carried on the fault_code output
package airlock_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAC  = 2'd1,
        PRESS = 2'd2,
        FAULT = 2'd3
    } airlock_state_t;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_DOOR    = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

endpackage

// File: rtl/airlock_tick_gen.sv
// airlock_tick_gen
//   Prescaler producing one tick every TICK_DIV enabled cycles.
//   Ports:
//     Clock   in  system clock, rising edge
//     Reset   in  synchronous active-high reset
//     enable  in  count while high (sequencer busy)
//     restart in  clear the count to 0 (entry into an operation)
//     tick    out high on the terminal count while enabled
module airlock_tick_gen #(
    parameter int TICK_DIV = 4
) (
    input  logic Clock,
    input  logic Reset,
    input  logic enable,
    input  logic restart,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge Clock) begin
        if (Reset || restart) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == LAST) ? '0 : count + CW'(1);
        end
    end

    assign tick = enable && (count == LAST);

endmodule

// File: rtl/airlock_pressure_ctrl.sv
// airlock_pressure_ctrl
//   Airlock chamber pressure sequencer. Runs evacuation and pressurisation,
//   modelling chamber pressure as a saturating level counter stepped once per
//   prescaled tick while the pump/vent is effective. Door interlocks force a
//   latched fault that is left only through clear_fault with both doors shut.
//
//   Optional build macro: AIRLOCK_TIMEOUT_EN adds a per-operation tick budget
//   (TIMEOUT_TICKS); running out of it while busy faults with code 10.
//
//   Ports:
//     Clock, Reset               clock / synchronous active-high reset
//     start_evac, start_press    operation requests, sampled in IDLE
//     abort                      stop the operation, hold the level
//     clear_fault                leave FAULT (doors must be closed)
//     inner_closed, outer_closed door-closed status
//     pump_ok                    pump/vent effective; ticks step only when high
//     level                      current chamber level
//     evacuated, pressurized     level at 0 / at FULL_LEVEL
//     pump_on, vent_on, busy     decoded from state
//     fault, fault_code          latched fault indication and cause
//     state_dbg                  current FSM state
//
//   Handshake: start_evac/start_press are level requests, accepted on the
//   edge where the FSM is IDLE and the request is legal; busy rises on that
//   same edge and there is no acknowledge beyond busy.
module airlock_pressure_ctrl
    import airlock_pkg::*;
#(
    parameter int LEVEL_W       = 8,
    parameter int FULL_LEVEL    = 200,
    parameter int STEP          = 10,
    parameter int TICK_DIV      = 4,
    parameter int TIMEOUT_TICKS = 32
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               start_evac,
    input  logic               start_press,
    input  logic               abort,
    input  logic               clear_fault,
    input  logic               inner_closed,
    input  logic               outer_closed,
    input  logic               pump_ok,
    output logic [LEVEL_W-1:0] level,
    output logic               evacuated,
    output logic               pressurized,
    output logic               pump_on,
    output logic               vent_on,
    output logic               busy,
    output logic               fault,
    output logic [1:0]         fault_code,
    output airlock_state_t     state_dbg
);

    // Illegal parameter sets stop elaboration rather than build a broken part.
    if (FULL_LEVEL >= (1 << LEVEL_W) || STEP < 1 || TICK_DIV < 1 ||
        TIMEOUT_TICKS < 1) begin : g_bad_params
        $error("airlock_pressure_ctrl: illegal parameter set");
    end

    localparam logic [LEVEL_W-1:0] FULL = LEVEL_W'(FULL_LEVEL);

    airlock_state_t     state, state_n;
    logic [LEVEL_W-1:0] level_n;
    logic [1:0]         code_n;
    logic               restart;
    logic               tick;
    logic               timeout_hit;
    logic               doors_closed;

    assign doors_closed = inner_closed && outer_closed;

    airlock_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .Clock  (Clock),
        .Reset  (Reset),
        .enable (busy),
        .restart(restart),
        .tick   (tick)
    );

    // Step arithmetic one bit wider than the level so neither direction wraps.
    logic [LEVEL_W:0]   lvl_w, step_w, diff_w, sum_w;
    logic [LEVEL_W-1:0] evac_level, press_level;

    assign lvl_w  = {1'b0, level};
    assign step_w = (LEVEL_W + 1)'(STEP);
    assign diff_w = lvl_w - step_w;
    assign sum_w  = lvl_w + step_w;

    assign evac_level  = (lvl_w > step_w) ? diff_w[LEVEL_W-1:0] : '0;
    assign press_level = (sum_w > {1'b0, FULL}) ? FULL : sum_w[LEVEL_W-1:0];

`ifdef AIRLOCK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);

    logic [TW-1:0] tcount;

    // Counts every tick of the operation, stepping or not.
    always_ff @(posedge Clock) begin
        if (Reset || restart) begin
            tcount <= '0;
        end else if (tick) begin
            tcount <= tcount + TW'(1);
        end
    end

    assign timeout_hit = tick && (tcount == TW'(TIMEOUT_TICKS - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= IDLE;
            level      <= FULL;
            fault_code <= FAULT_NONE;
        end else begin
            state      <= state_n;
            level      <= level_n;
            fault_code <= code_n;
        end
    end

    always_comb begin
        state_n = state;
        level_n = level;
        code_n  = fault_code;
        restart = 1'b0;
        unique case (state)
            IDLE: begin
                if (doors_closed && start_evac && !start_press && level != '0) begin
                    state_n = EVAC;
                    restart = 1'b1;
                end else if (doors_closed && start_press && !start_evac && level != FULL) begin
                    state_n = PRESS;
                    restart = 1'b1;
                end
            end
            EVAC, PRESS: begin
                if (!doors_closed) begin
                    state_n = FAULT;
                    code_n  = FAULT_DOOR;
                end else if (abort) begin
                    state_n = IDLE;
                end else if (tick && pump_ok) begin
                    level_n = (state == EVAC) ? evac_level : press_level;
                    // Completion beats a timeout landing on the same tick.
                    if (level_n == ((state == EVAC) ? '0 : FULL)) begin
                        state_n = IDLE;
                    end else if (timeout_hit) begin
                        state_n = FAULT;
                        code_n  = FAULT_TIMEOUT;
                    end
                end else if (timeout_hit) begin
                    state_n = FAULT;
                    code_n  = FAULT_TIMEOUT;
                end
            end
            FAULT: begin
                if (clear_fault && doors_closed) begin
                    state_n = IDLE;
                    code_n  = FAULT_NONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign evacuated   = (level == '0);
    assign pressurized = (level == FULL);
    assign pump_on     = (state == EVAC);
    assign vent_on     = (state == PRESS);
    assign busy        = (state == EVAC) || (state == PRESS);
    assign fault       = (state == FAULT);
    assign state_dbg   = state;

endmodule

// File: tb/tb_airlock_pressure_ctrl.sv
// tb_airlock_pressure_ctrl
//   Directed bench for airlock_pressure_ctrl: a default-parameter instance
//   (dut) and a FULL_LEVEL = 195 instance (dut2) for the saturation case.
module tb_airlock_pressure_ctrl;
    import airlock_pkg::*;

    // ---------------- clock ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- dut (defaults) ----------------
    logic           rst, start_evac, start_press, abort, clear_fault;
    logic           inner_closed, outer_closed, pump_ok;
    logic [7:0]     level;
    logic           evacuated, pressurized, pump_on, vent_on, busy, fault;
    logic [1:0]     fault_code;
    airlock_state_t state_dbg;

    airlock_pressure_ctrl dut (
        .Clock       (clk),
        .Reset       (rst),
        .start_evac  (start_evac),
        .start_press (start_press),
        .abort       (abort),
        .clear_fault (clear_fault),
        .inner_closed(inner_closed),
        .outer_closed(outer_closed),
        .pump_ok     (pump_ok),
        .level       (level),
        .evacuated   (evacuated),
        .pressurized (pressurized),
        .pump_on     (pump_on),
        .vent_on     (vent_on),
        .busy        (busy),
        .fault       (fault),
        .fault_code  (fault_code),
        .state_dbg   (state_dbg)
    );

    // ---------------- dut2 (FULL_LEVEL = 195) ----------------
    logic           b_rst, b_start_evac, b_start_press;
    logic [7:0]     b_level;
    logic           b_evacuated, b_pressurized, b_pump_on, b_vent_on, b_busy, b_fault;
    logic [1:0]     b_fault_code;
    airlock_state_t b_state_dbg;

    airlock_pressure_ctrl #(
        .FULL_LEVEL(195)
    ) dut2 (
        .Clock       (clk),
        .Reset       (b_rst),
        .start_evac  (b_start_evac),
        .start_press (b_start_press),
        .abort       (1'b0),
        .clear_fault (1'b0),
        .inner_closed(1'b1),
        .outer_closed(1'b1),
        .pump_ok     (1'b1),
        .level       (b_level),
        .evacuated   (b_evacuated),
        .pressurized (b_pressurized),
        .pump_on     (b_pump_on),
        .vent_on     (b_vent_on),
        .busy        (b_busy),
        .fault       (b_fault),
        .fault_code  (b_fault_code),
        .state_dbg   (b_state_dbg)
    );

    // ---------------- checking ----------------
    int tests_run    = 0;
    int tests_failed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then sample 1 ns later.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int n;

        rst = 1'b1; start_evac = 1'b0; start_press = 1'b0; abort = 1'b0;
        clear_fault = 1'b0; inner_closed = 1'b1; outer_closed = 1'b1; pump_ok = 1'b1;
        b_rst = 1'b1; b_start_evac = 1'b0; b_start_press = 1'b0;
        step(2);
        rst = 1'b0; b_rst = 1'b0;

        // Reset state
        chk("rst_level", level, 200);
        chk("rst_pressurized", pressurized, 1);
        chk("rst_evacuated", evacuated, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pump_vent", {pump_on, vent_on}, 0);
        chk("rst_fault", fault, 0);
        chk("rst_fault_code", fault_code, 0);
        chk("rst_state", state_dbg, IDLE);

        // Full evacuation: 80 busy cycles, 10 per 4 cycles
        start_evac = 1'b1;
        step(1);
        start_evac = 1'b0;
        chk("evac_start_busy", busy, 1);
        chk("evac_start_pump", pump_on, 1);
        n = 0;
        while (busy && n < 200) begin
            step(1);
            n++;
            if (n == 3)  chk("evac_lvl_k3", level, 200);
            if (n == 4)  chk("evac_lvl_k4", level, 190);
            if (n == 41) chk("evac_lvl_k41", level, 100);
        end
        chk("evac_cycles", n, 80);
        chk("evac_done_level", level, 0);
        chk("evac_done_flag", evacuated, 1);
        chk("evac_done_state", state_dbg, IDLE);
        chk("evac_done_pump", pump_on, 0);

        // Full pressurisation back to 200
        start_press = 1'b1;
        step(1);
        start_press = 1'b0;
        chk("press_start_vent", vent_on, 1);
        n = 0;
        while (busy && n < 200) begin
            step(1);
            n++;
            if (n == 4) chk("press_lvl_k4", level, 10);
        end
        chk("press_cycles", n, 80);
        chk("press_done_level", level, 200);
        chk("press_done_flag", pressurized, 1);

        // Already at target: request ignored
        start_press = 1'b1;
        step(1);
        start_press = 1'b0;
        chk("press_at_full_busy", busy, 0);
        chk("press_at_full_state", state_dbg, IDLE);

        // Door opens during EVAC at 120
        start_evac = 1'b1;
        step(1);
        start_evac = 1'b0;
        step(32);
        chk("door_pre_level", level, 120);
        chk("door_pre_busy", busy, 1);
        outer_closed = 1'b0;
        step(1);
        chk("door_fault", fault, 1);
        chk("door_code", fault_code, 1);
        chk("door_level", level, 120);
        chk("door_pump_off", pump_on, 0);
        clear_fault = 1'b1;
        step(1);
        clear_fault = 1'b0;
        chk("door_clear_open", fault, 1);
        start_evac = 1'b1;
        outer_closed = 1'b1;
        step(1);
        start_evac = 1'b0;
        chk("door_closed_no_clear", state_dbg, FAULT);
        clear_fault = 1'b1;
        step(1);
        clear_fault = 1'b0;
        chk("door_cleared_state", state_dbg, IDLE);
        chk("door_cleared_code", fault_code, 0);
        chk("door_cleared_level", level, 120);

        // Abort during PRESS at 150
        start_press = 1'b1;
        step(1);
        start_press = 1'b0;
        step(12);
        chk("abort_pre_level", level, 150);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        chk("abort_state", state_dbg, IDLE);
        chk("abort_level", level, 150);
        step(4);
        chk("abort_level_held", level, 150);

        // Both starts together: ignored
        start_evac = 1'b1; start_press = 1'b1;
        step(1);
        start_evac = 1'b0; start_press = 1'b0;
        chk("both_starts_busy", busy, 0);

        // Start with inner door open: ignored, no fault
        inner_closed = 1'b0; start_evac = 1'b1;
        step(1);
        start_evac = 1'b0; inner_closed = 1'b1;
        chk("door_open_start_busy", busy, 0);
        chk("door_open_start_fault", fault, 0);

        // Reset mid-ramp restores level 200
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        start_evac = 1'b1;
        step(1);
        start_evac = 1'b0;
        step(10);
        chk("midrst_pre_level", level, 180);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("midrst_level", level, 200);
        chk("midrst_busy", busy, 0);
        chk("midrst_state", state_dbg, IDLE);

        // pump_ok low: timeout build faults, otherwise stays busy
        pump_ok = 1'b0;
        start_evac = 1'b1;
        step(1);
        start_evac = 1'b0;
        chk("stall_busy", busy, 1);
`ifdef AIRLOCK_TIMEOUT_EN
        step(127);
        chk("tmo_pre_busy", busy, 1);
        chk("tmo_pre_fault", fault, 0);
        step(1);
        chk("tmo_fault", fault, 1);
        chk("tmo_code", fault_code, 2);
        chk("tmo_level", level, 200);
        clear_fault = 1'b1;
        step(1);
        clear_fault = 1'b0;
        chk("tmo_cleared", state_dbg, IDLE);
`else
        step(1000);
        chk("stall_still_busy", busy, 1);
        chk("stall_no_fault", fault, 0);
        chk("stall_code", fault_code, 0);
        chk("stall_level", level, 200);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        chk("stall_abort", state_dbg, IDLE);
`endif
        pump_ok = 1'b1;

        // dut2: FULL_LEVEL 195, evacuate then pressurise with saturation
        chk("b_rst_level", b_level, 195);
        b_start_evac = 1'b1;
        step(1);
        b_start_evac = 1'b0;
        n = 0;
        while (b_busy && n < 200) begin
            step(1);
            n++;
            if (n == 76) chk("b_evac_lvl_k76", b_level, 5);
        end
        chk("b_evac_cycles", n, 80);
        chk("b_evac_level", b_level, 0);
        b_start_press = 1'b1;
        step(1);
        b_start_press = 1'b0;
        step(76);
        chk("b_press_lvl_k76", b_level, 190);
        chk("b_press_busy_k76", b_busy, 1);
        step(4);
        chk("b_press_sat_level", b_level, 195);
        chk("b_press_pressurized", b_pressurized, 1);
        chk("b_press_done", b_busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
